// File: rtl/vsc8541_status_poller.sv
// Status/host read sequencer in front of the VSC8541 MDIO register reader.
// Optional macro VSC8541_POLLER_LINK_DEBOUNCE_EN: link must read up on two consecutive polls.
module vsc8541_status_poller #(
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned POLL_CYCLES    = 1000,
  parameter int unsigned TIMEOUT_CYCLES = 200,
  parameter logic [4:0]  STATUS_REG     = 5'd1
) (
  input  logic              clk,
  input  logic              i_reset_n,
  input  logic              i_host_req,
  input  logic [4:0]        i_host_reg,
  output logic              o_host_ack,
  output logic              o_host_dv,
  output logic [DATA_W-1:0] o_host_data,
  output logic              o_host_err,
  output logic [4:0]        o_phy_register,
  output logic              o_phy_read_en,
  input  logic [DATA_W-1:0] i_phy_data,
  input  logic              i_phy_dv,
  output logic [DATA_W-1:0] o_bmsr,
  output logic              o_status_dv,
  output logic              o_link_up,
  output logic              o_an_done,
  output logic              o_timeout,
  input  logic              i_clear_err
);

  localparam int unsigned PollW = (POLL_CYCLES > 2) ? $clog2(POLL_CYCLES) : 1;
  localparam int unsigned ToW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [PollW-1:0] PollReload  = PollW'(POLL_CYCLES - 1);
  localparam logic [ToW-1:0]   TimeoutLast = ToW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StCapture} state_e;

  state_e              r_state;
  logic [PollW-1:0]    r_poll_cnt;
  logic                r_poll_pending;
  logic                r_owner_host;
  logic [ToW-1:0]      r_wait_cnt;
  logic                r_host_dv;
  logic [DATA_W-1:0]   r_host_data;
  logic                r_host_err;
  logic [4:0]          r_phy_register;
  logic                r_phy_read_en;
  logic [DATA_W-1:0]   r_bmsr;
  logic                r_status_dv;
  logic                r_link_up;
  logic                r_an_done;
  logic                r_timeout;
`ifdef VSC8541_POLLER_LINK_DEBOUNCE_EN
  logic                r_link_seen;
`endif

  // Acceptance must be visible in the same cycle the request is taken.
  assign o_host_ack     = (r_state == StIdle) && i_host_req;
  assign o_host_dv      = r_host_dv;
  assign o_host_data    = r_host_data;
  assign o_host_err     = r_host_err;
  assign o_phy_register = r_phy_register;
  assign o_phy_read_en  = r_phy_read_en;
  assign o_bmsr         = r_bmsr;
  assign o_status_dv    = r_status_dv;
  assign o_link_up      = r_link_up;
  assign o_an_done      = r_an_done;
  assign o_timeout      = r_timeout;

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state        <= StIdle;
      r_poll_cnt     <= PollReload;
      r_poll_pending <= 1'b1;
      r_owner_host   <= 1'b0;
      r_wait_cnt     <= '0;
      r_host_dv      <= 1'b0;
      r_host_data    <= '0;
      r_host_err     <= 1'b0;
      r_phy_register <= '0;
      r_phy_read_en  <= 1'b0;
      r_bmsr         <= '0;
      r_status_dv    <= 1'b0;
      r_link_up      <= 1'b0;
      r_an_done      <= 1'b0;
      r_timeout      <= 1'b0;
`ifdef VSC8541_POLLER_LINK_DEBOUNCE_EN
      r_link_seen    <= 1'b0;
`endif
    end else begin
      r_phy_read_en <= 1'b0;
      r_host_dv     <= 1'b0;
      r_status_dv   <= 1'b0;
      if (i_clear_err) r_timeout <= 1'b0;

      case (r_state)
        StIdle: begin
          if (i_host_req) begin
            r_owner_host   <= 1'b1;
            r_phy_register <= i_host_reg;
            r_phy_read_en  <= 1'b1;
            r_state        <= StIssue;
          end else if (r_poll_pending) begin
            r_poll_pending <= 1'b0;
            r_owner_host   <= 1'b0;
            r_phy_register <= STATUS_REG;
            r_phy_read_en  <= 1'b1;
            r_state        <= StIssue;
          end
        end
        StIssue: begin
          r_wait_cnt <= '0;
          r_state    <= StWait;
        end
        StWait: begin
          // Results are registered here so they appear in the CAPTURE cycle.
          if (i_phy_dv) begin
            r_state <= StCapture;
            if (r_owner_host) begin
              r_host_dv   <= 1'b1;
              r_host_data <= i_phy_data;
              r_host_err  <= 1'b0;
            end else begin
              r_status_dv <= 1'b1;
              r_bmsr      <= i_phy_data;
              r_an_done   <= i_phy_data[5];
`ifdef VSC8541_POLLER_LINK_DEBOUNCE_EN
              if (!i_phy_data[2]) begin
                r_link_up   <= 1'b0;
                r_link_seen <= 1'b0;
              end else begin
                r_link_up   <= r_link_up | r_link_seen;
                r_link_seen <= 1'b1;
              end
`else
              r_link_up   <= i_phy_data[2];
`endif
            end
          end else if (r_wait_cnt == TimeoutLast) begin
            r_timeout <= 1'b1;
            r_state   <= StIdle;
            if (r_owner_host) begin
              r_host_dv   <= 1'b1;
              r_host_err  <= 1'b1;
              r_host_data <= '0;
            end
          end else begin
            r_wait_cnt <= r_wait_cnt + ToW'(1);
          end
        end
        StCapture: r_state <= StIdle;
        default:   r_state <= StIdle;
      endcase

      // Expiry overrides the pending-clear above so a coincident expiry is not lost.
      if (r_poll_cnt == '0) begin
        r_poll_cnt     <= PollReload;
        r_poll_pending <= 1'b1;
      end else begin
        r_poll_cnt <= r_poll_cnt - PollW'(1);
      end
    end
  end

endmodule

// File: tb/tb_vsc8541_status_poller.sv
// Directed bench for vsc8541_status_poller: transaction-level reference model checked every cycle,
// plus literal checkpoints for reset, host reads, poll/host collision, timeout, link drop and reset.
module tb_vsc8541_status_poller;

  localparam int unsigned DW   = 16;
  localparam int unsigned POLL = 20;
  localparam int unsigned TO   = 8;
  localparam logic [4:0]  SREG = 5'd1;

  logic          clk = 1'b0;
  logic          i_reset_n = 1'b0;
  logic          i_host_req = 1'b0;
  logic [4:0]    i_host_reg = 5'd0;
  logic          o_host_ack, o_host_dv, o_host_err;
  logic [DW-1:0] o_host_data;
  logic [4:0]    o_phy_register;
  logic          o_phy_read_en;
  logic [DW-1:0] i_phy_data;
  logic          i_phy_dv;
  logic [DW-1:0] o_bmsr;
  logic          o_status_dv, o_link_up, o_an_done, o_timeout;
  logic          i_clear_err = 1'b0;

  always #5 clk = ~clk;

  vsc8541_status_poller #(
    .DATA_W(DW), .POLL_CYCLES(POLL), .TIMEOUT_CYCLES(TO), .STATUS_REG(SREG)
  ) dut (
    .clk(clk), .i_reset_n(i_reset_n),
    .i_host_req(i_host_req), .i_host_reg(i_host_reg), .o_host_ack(o_host_ack),
    .o_host_dv(o_host_dv), .o_host_data(o_host_data), .o_host_err(o_host_err),
    .o_phy_register(o_phy_register), .o_phy_read_en(o_phy_read_en),
    .i_phy_data(i_phy_data), .i_phy_dv(i_phy_dv),
    .o_bmsr(o_bmsr), .o_status_dv(o_status_dv), .o_link_up(o_link_up),
    .o_an_done(o_an_done), .o_timeout(o_timeout), .i_clear_err(i_clear_err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int m_cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, m_cyc);
    end
  endtask

  // Reader model: answers one cycle after each strobe unless told to stay silent.
  logic          rd_never = 1'b0;
  logic          inj = 1'b0;
  logic [DW-1:0] poll_word = 16'h0024;
  logic          strobe_q = 1'b0;
  logic [4:0]    strobe_reg = 5'd0;

  initial forever begin
    @(negedge clk);
    strobe_q   = o_phy_read_en;
    strobe_reg = o_phy_register;
  end

  initial begin
    i_phy_dv   = 1'b0;
    i_phy_data = '0;
    forever begin
      @(posedge clk);
      #2;
      if (inj) begin
        i_phy_dv   = 1'b1;
        i_phy_data = 16'hFFFF;
      end else if (strobe_q && !rd_never) begin
        i_phy_dv   = 1'b1;
        i_phy_data = (strobe_reg == SREG) ? poll_word : 16'h0005 + {11'd0, strobe_reg};
      end else begin
        i_phy_dv   = 1'b0;
        i_phy_data = 16'hDEAD;
      end
    end
  end

  // Reference model, tracked in absolute cycle numbers since reset release.
  bit            m_pending, m_active, m_resolved, m_host, h_prev;
  int            m_strobe, m_free;
  logic          e_read_en, e_host_dv, e_host_err, e_status_dv, e_link, e_an, e_timeout;
  logic [4:0]    e_reg;
  logic [DW-1:0] e_host_data, e_bmsr;

  task automatic model_reset();
    m_cyc = -1; m_pending = 1; m_active = 0; m_resolved = 0; m_host = 0; h_prev = 0;
    m_strobe = 0; m_free = 0;
    e_read_en = 0; e_host_dv = 0; e_host_err = 0; e_status_dv = 0;
    e_link = 0; e_an = 0; e_timeout = 0; e_reg = '0; e_host_data = '0; e_bmsr = '0;
  endtask

  task automatic model_step();
    bit idle_p;
    int p;
    idle_p = !m_active;
    p = m_cyc;
    m_cyc++;
    e_read_en = 0; e_host_dv = 0; e_status_dv = 0;
    if (i_clear_err) e_timeout = 0;
    if (m_active && !m_resolved && p > m_strobe) begin
      if (i_phy_dv) begin
        m_resolved = 1;
        m_free = m_cyc + 1;
        if (m_host) begin
          e_host_dv = 1; e_host_err = 0; e_host_data = i_phy_data;
        end else begin
          e_status_dv = 1; e_bmsr = i_phy_data; e_an = i_phy_data[5];
`ifdef VSC8541_POLLER_LINK_DEBOUNCE_EN
          if (!i_phy_data[2]) begin
            e_link = 0; h_prev = 0;
          end else begin
            if (h_prev) e_link = 1;
            h_prev = 1;
          end
`else
          e_link = i_phy_data[2];
`endif
        end
      end else if (p - m_strobe == int'(TO)) begin
        m_resolved = 1;
        m_free = m_cyc;
        e_timeout = 1;
        if (m_host) begin
          e_host_dv = 1; e_host_err = 1; e_host_data = '0;
        end
      end
    end
    if (m_active && m_resolved && m_cyc >= m_free) m_active = 0;
    if (idle_p && (i_host_req || m_pending)) begin
      m_active = 1; m_resolved = 0; m_strobe = m_cyc; e_read_en = 1;
      if (i_host_req) begin
        m_host = 1; e_reg = i_host_reg;
      end else begin
        m_host = 0; m_pending = 0; e_reg = SREG;
      end
    end
    if ((m_cyc + 1) % int'(POLL) == 0) m_pending = 1;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge i_reset_n);
      if (!i_reset_n) model_reset();
      else model_step();
    end
  end

  initial forever begin
    @(negedge clk);
    if (i_reset_n) begin
      chk("read_en", o_phy_read_en, e_read_en);
      chk("phy_register", o_phy_register, e_reg);
      chk("host_ack", o_host_ack, !m_active && i_host_req);
      chk("host_dv", o_host_dv, e_host_dv);
      if (e_host_dv) begin
        chk("host_data", o_host_data, e_host_data);
        chk("host_err", o_host_err, e_host_err);
      end
      chk("status_dv", o_status_dv, e_status_dv);
      chk("bmsr", o_bmsr, e_bmsr);
      chk("link_up", o_link_up, e_link);
      chk("an_done", o_an_done, e_an);
      chk("timeout", o_timeout, e_timeout);
    end
  end

  task automatic wait_cyc(input int c);
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (m_cyc < c && guard < 500);
    chk("cycle_sync", m_cyc, c);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_read_en"}, o_phy_read_en, 0);
    chk({tag, "_reg"}, o_phy_register, 0);
    chk({tag, "_bmsr"}, o_bmsr, 0);
    chk({tag, "_link"}, o_link_up, 0);
    chk({tag, "_an"}, o_an_done, 0);
    chk({tag, "_timeout"}, o_timeout, 0);
    chk({tag, "_status_dv"}, o_status_dv, 0);
    chk({tag, "_host_dv"}, o_host_dv, 0);
    chk({tag, "_host_ack"}, o_host_ack, 0);
  endtask

  initial begin
    #30000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("rst");
    next_cycle();
    i_reset_n = 1'b1;

    // First poll right after release.
    wait_cyc(0);
    chk("p0_read_en", o_phy_read_en, 1);
    chk("p0_reg", o_phy_register, 1);
    wait_cyc(2);
    chk("p0_status_dv", o_status_dv, 1);
    chk("p0_bmsr", o_bmsr, 16'h0024);
    chk("p0_an", o_an_done, 1);
`ifdef VSC8541_POLLER_LINK_DEBOUNCE_EN
    chk("p0_link", o_link_up, 0);
`else
    chk("p0_link", o_link_up, 1);
`endif
    wait_cyc(23);
    chk("p1_link", o_link_up, 1);

    // Host read of register 2.
    wait_cyc(24); next_cycle();
    i_host_req = 1'b1; i_host_reg = 5'd2;
    wait_cyc(25);
    chk("h_ack", o_host_ack, 1);
    next_cycle();
    i_host_req = 1'b0;
    wait_cyc(26);
    chk("h_read_en", o_phy_read_en, 1);
    chk("h_reg", o_phy_register, 2);
    chk("h_ack_busy", o_host_ack, 0);
    wait_cyc(28);
    chk("h_dv", o_host_dv, 1);
    chk("h_data", o_host_data, 16'h0007);
    chk("h_err", o_host_err, 0);
    chk("h_status_dv", o_status_dv, 0);

    // Host request and poll expiry land in the same IDLE cycle.
    wait_cyc(38); next_cycle();
    i_host_req = 1'b1; i_host_reg = 5'd3;
    wait_cyc(39);
    chk("c_ack", o_host_ack, 1);
    next_cycle();
    i_host_req = 1'b0;
    wait_cyc(40);
    chk("c_host_reg", o_phy_register, 3);
    wait_cyc(42);
    chk("c_host_data", o_host_data, 16'h0008);
    wait_cyc(44);
    chk("c_poll_read_en", o_phy_read_en, 1);
    chk("c_poll_reg", o_phy_register, 1);
    wait_cyc(46);
    chk("c_status_dv", o_status_dv, 1);

    // Silent reader: poll times out, then a host read times out.
    wait_cyc(49); next_cycle();
    rd_never = 1'b1;
    wait_cyc(67); next_cycle();
    i_clear_err = 1'b1;
    wait_cyc(68);
    chk("t_before", o_timeout, 0);
    next_cycle();
    i_clear_err = 1'b0; i_host_req = 1'b1; i_host_reg = 5'd2;
    wait_cyc(69);
    chk("t_set_wins", o_timeout, 1);
    chk("t_bmsr_kept", o_bmsr, 16'h0024);
    chk("t_ack", o_host_ack, 1);
    next_cycle();
    i_host_req = 1'b0;
    wait_cyc(74); next_cycle();
    rd_never = 1'b0;
    wait_cyc(79);
    chk("t_host_dv", o_host_dv, 1);
    chk("t_host_err", o_host_err, 1);
    chk("t_host_data", o_host_data, 0);
    chk("t_link_kept", o_link_up, 1);
    wait_cyc(80); next_cycle();
    i_clear_err = 1'b1;
    wait_cyc(81);
    chk("t_still_set", o_timeout, 1);
    next_cycle();
    i_clear_err = 1'b0;
    wait_cyc(82);
    chk("t_cleared", o_timeout, 0);
    chk("t_poll_ok", o_status_dv, 1);

    // Link drop.
    wait_cyc(84); next_cycle();
    poll_word = 16'h0020;
    wait_cyc(101);
    chk("l_before", o_link_up, 1);
    wait_cyc(102);
    chk("l_status_dv", o_status_dv, 1);
    chk("l_link", o_link_up, 0);
    chk("l_bmsr", o_bmsr, 16'h0020);
    chk("l_an", o_an_done, 1);

    // Reset during WAIT, stray dv after release.
    wait_cyc(104); next_cycle();
    poll_word = 16'h0024; rd_never = 1'b1;
    wait_cyc(122); next_cycle();
    i_reset_n = 1'b0;
    #2;
    chk_all_zero("mid_rst");
    repeat (2) @(posedge clk);
    #1;
    rd_never = 1'b0; inj = 1'b1; i_reset_n = 1'b1;
    next_cycle();
    inj = 1'b0;
    wait_cyc(0);
    chk("r_read_en", o_phy_read_en, 1);
    chk("r_reg", o_phy_register, 1);
    wait_cyc(1);
    chk("r_stray_dv", o_status_dv, 0);
    chk("r_bmsr_zero", o_bmsr, 0);
    wait_cyc(2);
    chk("r_status_dv", o_status_dv, 1);
    chk("r_bmsr", o_bmsr, 16'h0024);
    wait_cyc(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
